// File: rtl/acs_unit_k3.sv
// -----------------------------------------------------------------------------
// acs_unit_k3
// Add-compare-select unit for a K=3, rate-1/2 Viterbi decoder built on the
// generator pair 7/5 (octal). The trellis has four states {s1,s0}. Input bit u
// moves state {s1,s0} to {u,s1}.
//
// Each accepted step takes the current path metrics (pm_in, or the initial
// metrics on a frame start) and the four branch metrics (bm_in). For every
// next state it adds the branch metric to each of the two predecessor metrics
// and keeps the smaller sum, recording which predecessor won. The four
// survivors are then normalised by subtracting their minimum and clipped to
// 3 bits. Results appear one cycle after the step.
//
// Packing:
//   bm_in[1:0]=sym 00, [3:2]=sym 01, [5:4]=sym 10, [7:6]=sym 11
//   pm_in/pm_out[2:0]=state0, [5:3]=state1, [8:6]=state2, [11:9]=state3
//   dec_out[n] = 0 : lower-numbered predecessor, 1 : higher-numbered one
// -----------------------------------------------------------------------------
module acs_unit_k3 #(
  parameter logic [2:0] INIT_MAX = 3'd7  // start metric for states 1..3
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        in_valid,
  input  logic        frame_start,
  input  logic [7:0]  bm_in,
  input  logic [11:0] pm_in,
  output logic [11:0] pm_out,
  output logic [3:0]  dec_out,
  output logic        out_valid,
  output logic        norm_flag,
  output logic [7:0]  step_cnt
);

  localparam logic [2:0] PM_SAT   = 3'd7;
  localparam logic [7:0] CNT_MAX  = 8'd255;

  // Branch symbol indices into the branch-metric vector.
  localparam int SYM_00 = 0;
  localparam int SYM_01 = 1;
  localparam int SYM_10 = 2;
  localparam int SYM_11 = 3;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [11:0] pm_q,        pm_d;
  logic [3:0]  dec_q,       dec_d;
  logic        out_valid_q, out_valid_d;
  logic        norm_q,      norm_d;
  logic [7:0]  cnt_q,       cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational datapath signals
  // ---------------------------------------------------------------------------
  logic        init_step;        // frame_start qualified by in_valid
  logic [2:0]  pm_cur  [4];      // metrics feeding this step
  logic [1:0]  bm      [4];      // branch metric per symbol 00,01,10,11
  logic [3:0]  cand_lo [4];      // candidate via lower-numbered predecessor
  logic [3:0]  cand_hi [4];      // candidate via higher-numbered predecessor
  logic [3:0]  surv    [4];      // selected survivor sums
  logic [3:0]  min_01, min_23, min_all;
  logic [3:0]  normed  [4];

  assign init_step = in_valid & frame_start;

  // Unpack the metric and branch vectors, substituting the initial metrics on
  // a frame start so the decoder begins anchored on state 0.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    for (int s = 0; s < 4; s++) begin
      pm_cur[s] = pm_in[3*s +: 3];
      bm[s]     = bm_in[2*s +: 2];
    end
    if (init_step) begin
      pm_cur[0] = 3'd0;
      pm_cur[1] = INIT_MAX;
      pm_cur[2] = INIT_MAX;
      pm_cur[3] = INIT_MAX;
    end
  end

  // Form the two candidate sums for each next state. Widening to 4 bits keeps
  // the worst case (7 + 3 = 10) exact without any overflow handling.
  always_comb begin
    // next state 0 <- state0 on 00, state1 on 11
    cand_lo[0] = {1'b0, pm_cur[0]} + {2'b00, bm[SYM_00]};
    cand_hi[0] = {1'b0, pm_cur[1]} + {2'b00, bm[SYM_11]};
    // next state 1 <- state2 on 10, state3 on 01
    cand_lo[1] = {1'b0, pm_cur[2]} + {2'b00, bm[SYM_10]};
    cand_hi[1] = {1'b0, pm_cur[3]} + {2'b00, bm[SYM_01]};
    // next state 2 <- state0 on 11, state1 on 00
    cand_lo[2] = {1'b0, pm_cur[0]} + {2'b00, bm[SYM_11]};
    cand_hi[2] = {1'b0, pm_cur[1]} + {2'b00, bm[SYM_00]};
    // next state 3 <- state2 on 01, state3 on 10
    cand_lo[3] = {1'b0, pm_cur[2]} + {2'b00, bm[SYM_01]};
    cand_hi[3] = {1'b0, pm_cur[3]} + {2'b00, bm[SYM_10]};
  end

  // Compare-select: the upper predecessor wins only when strictly smaller, so
  // ties resolve to the lower-numbered predecessor (decision 0).
  always_comb begin
    dec_d = 4'h0;
    for (int n = 0; n < 4; n++) begin
      surv[n] = cand_lo[n];
      if (cand_hi[n] < cand_lo[n]) begin
        surv[n]  = cand_hi[n];
        dec_d[n] = 1'b1;
      end
    end
  end

  // Find the smallest survivor with a two-level compare tree.
  always_comb begin
    min_01  = (surv[1] < surv[0]) ? surv[1] : surv[0];
    min_23  = (surv[3] < surv[2]) ? surv[3] : surv[2];
    min_all = (min_23 < min_01) ? min_23 : min_01;
  end

  // Normalise by the minimum, clip to the 3-bit metric range and repack.
  always_comb begin
    pm_d = 12'h000;
    for (int n = 0; n < 4; n++) begin
      normed[n] = surv[n] - min_all;
      pm_d[3*n +: 3] = (normed[n] > {1'b0, PM_SAT}) ? PM_SAT : normed[n][2:0];
    end
    norm_d = (min_all != 4'd0);
  end

  // Step counter: restart at 1 on a frame start, otherwise count up and stick
  // at the top value rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (init_step) begin
      cnt_d = 8'd1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign out_valid_d = in_valid;

  // Output registers: load results on accepted steps, hold otherwise; the
  // valid strobe follows in_valid with one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q        <= 12'h000;
      dec_q       <= 4'h0;
      out_valid_q <= 1'b0;
      norm_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      out_valid_q <= out_valid_d;
      if (in_valid) begin
        pm_q   <= pm_d;
        dec_q  <= dec_d;
        norm_q <= norm_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign pm_out    = pm_q;
  assign dec_out   = dec_q;
  assign out_valid = out_valid_q;
  assign norm_flag = norm_q;
  assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_acs_unit_k3.sv
// -----------------------------------------------------------------------------
// tb_acs_unit_k3
// Self-checking bench for acs_unit_k3. Each driven step pushes its expected
// result (from an independent trellis model) onto a scoreboard queue; the
// entry is popped and compared one clock later when the DUT presents it.
// -----------------------------------------------------------------------------
module tb_acs_unit_k3;

  localparam logic [2:0] INIT_MAX = 3'd7;

  typedef struct {
    logic [11:0] pm;
    logic [3:0]  dec;
    logic        norm;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        frame_start;
  logic [7:0]  bm_in;
  logic [11:0] pm_in;
  logic [11:0] pm_out;
  logic [3:0]  dec_out;
  logic        out_valid;
  logic        norm_flag;
  logic [7:0]  step_cnt;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  int   model_cnt = 0;

  // Trellis tables: predecessor and branch symbol for each next state.
  int pred_lo[4] = '{0, 2, 0, 2};
  int sym_lo [4] = '{0, 2, 3, 1};
  int pred_hi[4] = '{1, 3, 1, 3};
  int sym_hi [4] = '{3, 1, 0, 2};

  acs_unit_k3 #(.INIT_MAX(INIT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .bm_in       (bm_in),
    .pm_in       (pm_in),
    .pm_out      (pm_out),
    .dec_out     (dec_out),
    .out_valid   (out_valid),
    .norm_flag   (norm_flag),
    .step_cnt    (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model of one ACS step (step counter handled by the caller).
  function automatic exp_t model(input logic fs, input logic [7:0] bm, input logic [11:0] pm);
    exp_t e;
    int p[4];
    int b[4];
    int s[4];
    int mn;
    int r;
    e.pm  = '0;
    e.dec = '0;
    e.cnt = '0;
    for (int i = 0; i < 4; i++) begin
      b[i] = int'(bm[2*i +: 2]);
      if (fs) p[i] = (i == 0) ? 0 : int'(INIT_MAX);
      else    p[i] = int'(pm[3*i +: 3]);
    end
    for (int n = 0; n < 4; n++) begin
      int a, c;
      a = p[pred_lo[n]] + b[sym_lo[n]];
      c = p[pred_hi[n]] + b[sym_hi[n]];
      if (c < a) begin s[n] = c; e.dec[n] = 1'b1; end
      else       begin s[n] = a; e.dec[n] = 1'b0; end
    end
    mn = s[0];
    for (int n = 1; n < 4; n++) if (s[n] < mn) mn = s[n];
    e.norm = (mn != 0);
    for (int n = 0; n < 4; n++) begin
      r = s[n] - mn;
      if (r > 7) r = 7;
      e.pm[3*n +: 3] = 3'(r);
    end
    return e;
  endfunction

  // Compare DUT outputs against the oldest scoreboard entry.
  task automatic check_out(input string tag);
    exp_t e;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      last_exp = e;
      check({tag, ".pm_out"},    32'(pm_out),    32'(e.pm));
      check({tag, ".dec_out"},   32'(dec_out),   32'(e.dec));
      check({tag, ".norm_flag"}, 32'(norm_flag), 32'(e.norm));
      check({tag, ".step_cnt"},  32'(step_cnt),  32'(e.cnt));
    end
  endtask

  // Drive one step, push its expectation, and check it after the edge.
  task automatic step(input string tag, input logic fs, input logic [7:0] bm, input logic [11:0] pm);
    exp_t e;
    in_valid    = 1'b1;
    frame_start = fs;
    bm_in       = bm;
    pm_in       = pm;
    e = model(fs, bm, pm);
    if (fs) model_cnt = 1;
    else if (model_cnt < 255) model_cnt++;
    e.cnt = 8'(model_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // Idle cycle: outputs must hold and out_valid must drop.
  task automatic idle(input string tag);
    in_valid    = 1'b0;
    frame_start = 1'b1;            // must be ignored without in_valid
    bm_in       = 8'($urandom);
    pm_in       = 12'($urandom);
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".pm_hold"},   32'(pm_out),    32'(last_exp.pm));
    check({tag, ".dec_hold"},  32'(dec_out),   32'(last_exp.dec));
    check({tag, ".norm_hold"}, 32'(norm_flag), 32'(last_exp.norm));
    check({tag, ".cnt_hold"},  32'(step_cnt),  32'(last_exp.cnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".pm_out"},    32'(pm_out),    32'd0);
    check({tag, ".dec_out"},   32'(dec_out),   32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".norm_flag"}, 32'(norm_flag), 32'd0);
    check({tag, ".step_cnt"},  32'(step_cnt),  32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b1;
    frame_start = 1'b1;
    bm_in       = 8'h94;
    pm_in       = 12'h000;

    // Reset state, held across a clock edge despite in_valid high.
    #2;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_hold");

    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;

    // Frame start with known expected values.
    step("frame_start", 1'b1, 8'h94, 12'hABC);
    check("fs.pm_literal",  32'(pm_out),  32'hEB8);
    check("fs.dec_literal", 32'(dec_out), 32'h0);
    check("fs.cnt_literal", 32'(step_cnt), 32'd1);

    // Normalisation: all metrics 3, all branches 1.
    step("normalise", 1'b0, 8'h55, 12'h6DB);
    check("norm.pm_literal",   32'(pm_out),    32'h000);
    check("norm.flag_literal", 32'(norm_flag), 32'd1);

    // Upper predecessors win everywhere.
    step("upper_pred", 1'b0, 8'h00, 12'h145);
    check("upper.dec_literal", 32'(dec_out),   32'hF);
    check("upper.pm_literal",  32'(pm_out),    32'h000);
    check("upper.norm_literal", 32'(norm_flag), 32'd0);

    // Stall for three cycles.
    for (int i = 0; i < 3; i++) idle("stall");

    // Saturation of normalised metrics: large spread after frame start.
    step("sat_fs", 1'b1, 8'h03, 12'h000);
    step("sat_spread", 1'b0, 8'hFC, 12'hFF8);

    // Back-to-back random steps.
    for (int i = 0; i < 12; i++)
      step("random", 1'b0, 8'($urandom), 12'($urandom));

    // Reset mid-stream: assert between edges while steps keep coming.
    in_valid = 1'b1;
    bm_in    = 8'h1B;
    pm_in    = 12'h123;
    #2;
    rst = 1'b0;
    #1;
    check_zero("mid_reset_async");
    @(posedge clk);
    #1;
    check_zero("mid_reset_hold");
    @(negedge clk);
    rst       = 1'b1;
    model_cnt = 0;
    step("post_reset", 1'b0, 8'h27, 12'h2A1);
    step("post_reset2", 1'b0, 8'($urandom), 12'($urandom));

    // Counter saturation: one frame start followed by 299 more steps.
    step("cnt_fs", 1'b1, 8'($urandom), 12'($urandom));
    for (int i = 0; i < 299; i++)
      step("cnt_run", 1'b0, 8'($urandom), 12'($urandom));
    check("cnt.saturated", 32'(step_cnt), 32'd255);
    idle("cnt_idle");
    step("cnt_refs", 1'b1, 8'h94, 12'h000);
    check("cnt.restart", 32'(step_cnt), 32'd1);

    in_valid = 1'b0;
    check("sb.drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
